// File: rtl/udp_arb_pkg.sv
// rtl/udp_arb_pkg.sv - shared types and constants for the UDP transmit arbiter
package udp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int CH_IMG = 0;
    localparam int CH_STS = 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IMG  = 2'b01;
    localparam logic [1:0] GRANT_STS  = 2'b10;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// rtl/udp_tx_arbiter_if.sv - source and UDP engine handshake bundle for the arbiter
interface udp_tx_arbiter_if;

    logic        img_tx_start;
    logic [15:0] img_tx_data_num;
    logic [31:0] img_tx_data;
    logic        img_tx_req;
    logic        img_tx_done;

    logic        sts_tx_start;
    logic [15:0] sts_tx_data_num;
    logic [31:0] sts_tx_data;
    logic        sts_tx_req;
    logic        sts_tx_done;

    logic        eth_tx_start;
    logic [15:0] eth_tx_data_num;
    logic [31:0] eth_tx_data;
    logic        eth_tx_req;
    logic        eth_tx_done;

    modport slave (
        input  img_tx_start, img_tx_data_num, img_tx_data,
        output img_tx_req, img_tx_done,
        input  sts_tx_start, sts_tx_data_num, sts_tx_data,
        output sts_tx_req, sts_tx_done,
        output eth_tx_start, eth_tx_data_num, eth_tx_data,
        input  eth_tx_req, eth_tx_done
    );

    modport master (
        output img_tx_start, img_tx_data_num, img_tx_data,
        input  img_tx_req, img_tx_done,
        output sts_tx_start, sts_tx_data_num, sts_tx_data,
        input  sts_tx_req, sts_tx_done,
        input  eth_tx_start, eth_tx_data_num, eth_tx_data,
        output eth_tx_req, eth_tx_done
    );

endinterface

// File: rtl/udp_arb_chan.sv
// rtl/udp_arb_chan.sv - per-channel request latch: pending bit, byte count, sticky overflow
module udp_arb_chan
    import udp_arb_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [15:0] data_num,
    input  logic        clr,
    output logic        pending,
    output logic [15:0] num,
    output logic        ovf
);

    logic        pending_q, pending_d;
    logic [15:0] num_q, num_d;
    logic        ovf_q, ovf_d;

    // A start arriving in the same cycle the arbiter consumes the request is a fresh packet.
    always_comb begin
        pending_d = pending_q;
        num_d     = num_q;
        ovf_d     = ovf_q;
        if (clr) begin
            pending_d = 1'b0;
        end
        if (start) begin
            if (pending_q && !clr) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                num_d     = data_num;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending_q <= 1'b0;
            num_q     <= 16'd0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign num     = num_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - shares one UDP transmit engine between the image and status sources
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter logic [15:0] GAP_CYCLES = 16'd12,
    parameter logic [23:0] TIMEOUT    = 24'h0F_FF_FF,
    parameter logic [3:0]  HI_MAX     = 4'd4
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    udp_tx_arbiter_if.slave bus,
    output logic [1:0]      grant,
    output logic            tx_timeout,
    output logic            img_ovf,
    output logic            sts_ovf
);

    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] eth_num_q, eth_num_d;
    logic        eth_start_q, eth_start_d;
    logic        img_done_q, img_done_d;
    logic        sts_done_q, sts_done_d;
    logic        timeout_q, timeout_d;
    logic [23:0] wdog_q, wdog_d;
    logic [15:0] gap_q, gap_d;
    logic [3:0]  hi_q, hi_d;

    logic        img_pend, sts_pend;
    logic [15:0] img_num, sts_num;
    logic        img_clr, sts_clr;
    logic        busy;

    udp_arb_chan u_img (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (bus.img_tx_start),
        .data_num (bus.img_tx_data_num),
        .clr      (img_clr),
        .pending  (img_pend),
        .num      (img_num),
        .ovf      (img_ovf)
    );

    udp_arb_chan u_sts (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (bus.sts_tx_start),
        .data_num (bus.sts_tx_data_num),
        .clr      (sts_clr),
        .pending  (sts_pend),
        .num      (sts_num),
        .ovf      (sts_ovf)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        eth_num_d   = eth_num_q;
        eth_start_d = 1'b0;
        img_done_d  = 1'b0;
        sts_done_d  = 1'b0;
        timeout_d   = 1'b0;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        hi_d        = hi_q;
        img_clr     = 1'b0;
        sts_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (img_pend || sts_pend) begin
                    // STS wins unless it has already taken HI_MAX grants in a row over a waiting IMG.
                    if (sts_pend && !(hi_q == HI_MAX && img_pend)) begin
                        grant_d = GRANT_STS;
                        if (!img_pend) begin
                            hi_d = 4'd0;
                        end else if (hi_q < HI_MAX) begin
                            hi_d = hi_q + 4'd1;
                        end
                    end else begin
                        grant_d = GRANT_IMG;
                        hi_d    = 4'd0;
                    end
                    state_d = ST_START;
                end
            end

            ST_START: begin
                eth_start_d = 1'b1;
                eth_num_d   = grant_q[CH_STS] ? sts_num : img_num;
                img_clr     = grant_q[CH_IMG];
                sts_clr     = grant_q[CH_STS];
                wdog_d      = 24'd0;
                state_d     = ST_BUSY;
            end

            ST_BUSY: begin
                if (bus.eth_tx_done || wdog_q == TIMEOUT - 24'd1) begin
                    timeout_d  = !bus.eth_tx_done;
                    img_done_d = grant_q[CH_IMG];
                    sts_done_d = grant_q[CH_STS];
                    grant_d    = GRANT_NONE;
                    gap_d      = 16'd0;
                    state_d    = ST_GAP;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_CYCLES - 16'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GRANT_NONE;
            eth_num_q   <= 16'd0;
            eth_start_q <= 1'b0;
            img_done_q  <= 1'b0;
            sts_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wdog_q      <= 24'd0;
            gap_q       <= 16'd0;
            hi_q        <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            eth_num_q   <= eth_num_d;
            eth_start_q <= eth_start_d;
            img_done_q  <= img_done_d;
            sts_done_q  <= sts_done_d;
            timeout_q   <= timeout_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            hi_q        <= hi_d;
        end
    end

    // Payload path stays combinational so the source FIFO latency is all the engine sees.
    assign busy           = (state_q == ST_BUSY);
    assign bus.img_tx_req = busy && grant_q[CH_IMG] && bus.eth_tx_req;
    assign bus.sts_tx_req = busy && grant_q[CH_STS] && bus.eth_tx_req;

    always_comb begin
        bus.eth_tx_data = 32'd0;
        if (busy) begin
            bus.eth_tx_data = grant_q[CH_STS] ? bus.sts_tx_data : bus.img_tx_data;
        end
    end

    assign bus.eth_tx_start    = eth_start_q;
    assign bus.eth_tx_data_num = eth_num_q;
    assign bus.img_tx_done     = img_done_q;
    assign bus.sts_tx_done     = sts_done_q;
    assign grant               = grant_q;
    assign tx_timeout          = timeout_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - directed self-checking bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

    localparam int GAP = 12;
    localparam int TMO = 100;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] grant;
    logic       tx_timeout;
    logic       img_ovf;
    logic       sts_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] img_q[$];
    logic [15:0] sts_q[$];

    udp_tx_arbiter_if bus ();

    udp_tx_arbiter #(
        .GAP_CYCLES (16'd12),
        .TIMEOUT    (24'd100),
        .HI_MAX     (4'd4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bus        (bus),
        .grant      (grant),
        .tx_timeout (tx_timeout),
        .img_ovf    (img_ovf),
        .sts_ovf    (sts_ovf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every granted packet must carry the oldest accepted byte count of its channel.
    always @(negedge sys_clk) begin
        if (!sys_rst && bus.eth_tx_start) begin
            if (grant == 2'b01 && img_q.size() > 0) begin
                chk("img_num", {16'd0, bus.eth_tx_data_num}, {16'd0, img_q.pop_front()});
            end else if (grant == 2'b10 && sts_q.size() > 0) begin
                chk("sts_num", {16'd0, bus.eth_tx_data_num}, {16'd0, sts_q.pop_front()});
            end else begin
                chk("unexpected_start_grant", {30'd0, grant}, 32'hFFFF_FFFF);
            end
        end
    end

    task automatic wait_eth_start(input int max_cyc, output int lat, output logic [1:0] g);
        lat = 0;
        g   = 2'b11;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge sys_clk);
            if (bus.eth_tx_start) begin
                lat = k;
                g   = grant;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL eth_start_wait: observed none expected start within %0d cycles", max_cyc);
        end
    endtask

    task automatic route_check(input logic is_sts);
        logic [31:0] di, ds;
        @(posedge sys_clk); #1;
        di = $urandom;
        ds = $urandom;
        bus.eth_tx_req  = 1'b1;
        bus.img_tx_data = di;
        bus.sts_tx_data = ds;
        @(negedge sys_clk);
        chk("img_req_busy", {31'd0, bus.img_tx_req}, {31'd0, !is_sts});
        chk("sts_req_busy", {31'd0, bus.sts_tx_req}, {31'd0, is_sts});
        chk("eth_data_mux", bus.eth_tx_data, is_sts ? ds : di);
        @(posedge sys_clk); #1;
        bus.eth_tx_req = 1'b0;
        @(negedge sys_clk);
        chk("req_low", {30'd0, bus.img_tx_req, bus.sts_tx_req}, 32'd0);
    endtask

    task automatic finish_packet(input logic exp_img, input logic exp_sts);
        @(posedge sys_clk); #1;
        bus.eth_tx_done = 1'b1;
        @(posedge sys_clk); #1;
        bus.eth_tx_done = 1'b0;
        @(negedge sys_clk);
        chk("img_done", {31'd0, bus.img_tx_done}, {31'd0, exp_img});
        chk("sts_done", {31'd0, bus.sts_tx_done}, {31'd0, exp_sts});
        chk("grant_after_done", {30'd0, grant}, 32'd0);
    endtask

    task automatic start_img(input logic [15:0] n, input logic push);
        bus.img_tx_start    = 1'b1;
        bus.img_tx_data_num = n;
        if (push) img_q.push_back(n);
    endtask

    task automatic start_sts(input logic [15:0] n, input logic push);
        bus.sts_tx_start    = 1'b1;
        bus.sts_tx_data_num = n;
        if (push) sts_q.push_back(n);
    endtask

    task automatic clear_starts();
        bus.img_tx_start = 1'b0;
        bus.sts_tx_start = 1'b0;
    endtask

    initial begin
        int lat;
        logic [1:0] g;
        logic [1:0] exp_g;
        int seen;

        sys_rst             = 1'b1;
        bus.img_tx_start    = 1'b0;
        bus.img_tx_data_num = 16'd0;
        bus.img_tx_data     = 32'hDEAD_BEEF;
        bus.sts_tx_start    = 1'b0;
        bus.sts_tx_data_num = 16'd0;
        bus.sts_tx_data     = 32'hCAFE_F00D;
        bus.eth_tx_req      = 1'b1;
        bus.eth_tx_done     = 1'b0;

        // Reset state, with engine strobes high to show they are ignored outside BUSY.
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_eth_start", {31'd0, bus.eth_tx_start}, 32'd0);
        chk("rst_eth_num", {16'd0, bus.eth_tx_data_num}, 32'd0);
        chk("rst_eth_data", bus.eth_tx_data, 32'd0);
        chk("rst_reqs", {30'd0, bus.img_tx_req, bus.sts_tx_req}, 32'd0);
        chk("rst_flags", {28'd0, tx_timeout, img_ovf, sts_ovf, bus.img_tx_done}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst        = 1'b0;
        bus.eth_tx_req = 1'b0;

        // Single IMG packet: three cycles to eth_tx_start, data routed, done one cycle later.
        @(posedge sys_clk); #1;
        start_img(16'd520, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        wait_eth_start(20, lat, g);
        chk("img_latency", lat, 3);
        chk("img_grant", {30'd0, g}, 32'h1);
        route_check(1'b0);
        finish_packet(1'b1, 1'b0);
        @(posedge sys_clk); #1;
        bus.eth_tx_req = 1'b1;
        @(negedge sys_clk);
        chk("gap_img_req", {31'd0, bus.img_tx_req}, 32'd0);
        chk("gap_eth_data", bus.eth_tx_data, 32'd0);
        @(posedge sys_clk); #1;
        bus.eth_tx_req = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;

        // Simultaneous starts: STS first, IMG after the gap.
        start_img(16'd1500, 1'b1);
        start_sts(16'd40, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        wait_eth_start(20, lat, g);
        chk("both_latency", lat, 3);
        chk("both_first_grant", {30'd0, g}, 32'h2);
        route_check(1'b1);
        finish_packet(1'b0, 1'b1);
        // Counted from the cycle after the done pulse: GAP+3 from eth_tx_done itself.
        wait_eth_start(40, lat, g);
        chk("done_to_start", lat, GAP + 2);
        chk("both_second_grant", {30'd0, g}, 32'h1);
        route_check(1'b0);
        finish_packet(1'b1, 1'b0);
        repeat (20) @(posedge sys_clk);
        #1;

        // Starvation guard: STS keeps re-requesting, IMG gets every fifth grant.
        start_img(16'd900, 1'b1);
        start_sts(16'd100, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        for (int p = 0; p < 10; p++) begin
            exp_g = (p % 5 == 4) ? 2'b01 : 2'b10;
            wait_eth_start(60, lat, g);
            chk($sformatf("starve_grant_%0d", p), {30'd0, g}, {30'd0, exp_g});
            if (p < 8) begin
                @(posedge sys_clk); #1;
                if (exp_g == 2'b01) start_img(16'(901 + p), 1'b1);
                else                start_sts(16'(101 + p), 1'b1);
                @(posedge sys_clk); #1;
                clear_starts();
            end
            finish_packet(exp_g[0], exp_g[1]);
        end
        chk("starve_no_ovf", {30'd0, img_ovf, sts_ovf}, 32'd0);
        repeat (20) @(posedge sys_clk);
        #1;

        // Second start while pending is dropped and flagged.
        start_img(16'd300, 1'b1);
        @(posedge sys_clk); #1;
        start_img(16'd777, 1'b0);
        @(posedge sys_clk); #1;
        clear_starts();
        @(negedge sys_clk);
        chk("img_ovf_set", {31'd0, img_ovf}, 32'd1);
        chk("sts_ovf_clear", {31'd0, sts_ovf}, 32'd0);
        wait_eth_start(20, lat, g);
        chk("ovf_latency", lat, 1);
        finish_packet(1'b1, 1'b0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (bus.eth_tx_start) seen++;
        end
        chk("ovf_single_packet", seen, 0);
        chk("img_ovf_sticky", {31'd0, img_ovf}, 32'd1);
        @(posedge sys_clk); #1;

        // Watchdog: engine never completes.
        start_sts(16'd64, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        wait_eth_start(20, lat, g);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge sys_clk);
            if (tx_timeout) begin
                lat = k;
                break;
            end
        end
        chk("timeout_cycles", lat, TMO);
        chk("timeout_sts_done", {31'd0, bus.sts_tx_done}, 32'd1);
        chk("timeout_img_done", {31'd0, bus.img_tx_done}, 32'd0);
        @(posedge sys_clk); #1;
        start_img(16'd200, 1'b1);
        @(negedge sys_clk);
        chk("timeout_gap_grant", {30'd0, grant}, 32'd0);
        chk("timeout_pulse_once", {31'd0, tx_timeout}, 32'd0);
        @(posedge sys_clk); #1;
        clear_starts();
        // Request lands two cycles into the gap, so it waits out the remainder.
        wait_eth_start(40, lat, g);
        chk("post_timeout_latency", lat, GAP + 1);
        chk("post_timeout_grant", {30'd0, g}, 32'h1);
        finish_packet(1'b1, 1'b0);
        repeat (20) @(posedge sys_clk);
        #1;

        // Done on the same cycle the watchdog would expire: done wins.
        start_sts(16'd65, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        wait_eth_start(20, lat, g);
        repeat (TMO - 1) @(posedge sys_clk);
        #1;
        bus.eth_tx_done = 1'b1;
        @(posedge sys_clk); #1;
        bus.eth_tx_done = 1'b0;
        @(negedge sys_clk);
        chk("edge_no_timeout", {31'd0, tx_timeout}, 32'd0);
        chk("edge_sts_done", {31'd0, bus.sts_tx_done}, 32'd1);
        repeat (20) @(posedge sys_clk);
        #1;

        // Reset mid-packet aborts silently.
        start_sts(16'd66, 1'b1);
        @(posedge sys_clk); #1;
        clear_starts();
        wait_eth_start(20, lat, g);
        @(posedge sys_clk); #1;
        sys_rst        = 1'b1;
        bus.eth_tx_req = 1'b1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("midrst_grant", {30'd0, grant}, 32'd0);
        chk("midrst_reqs", {30'd0, bus.img_tx_req, bus.sts_tx_req}, 32'd0);
        chk("midrst_eth_data", bus.eth_tx_data, 32'd0);
        chk("midrst_eth_num", {16'd0, bus.eth_tx_data_num}, 32'd0);
        chk("midrst_ovf", {30'd0, img_ovf, sts_ovf}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst        = 1'b0;
        bus.eth_tx_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (bus.sts_tx_done || bus.img_tx_done || bus.eth_tx_start) seen++;
        end
        chk("midrst_no_done", seen, 0);

        chk("scoreboard_img_empty", img_q.size(), 0);
        chk("scoreboard_sts_empty", sts_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
